// File: rtl/dmux4way4_pkg.sv
// Shared constants and state type for the registered 4-way demultiplexer.
package dmux4way4_pkg;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  localparam logic [3:0] FULL_MASK = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

endpackage

// File: rtl/dmux_ch_reg.sv
// One channel holding register with load enable and synchronous reset.
module dmux_ch_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold value unless loaded; reset clears.
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/dmux4way4_seq.sv
// Registered 4-way demultiplexer: routes a nibble stream into channels a..d,
// tracks frame fill, raises frame_done when all four channels are fresh.
// Optional even-parity checking on the input bus: DMUX4WAY4_PARITY_EN.
module dmux4way4_seq
  import dmux4way4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [1:0]       sel,
  input  logic             auto_mode,
  input  logic             clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_valid,
  output logic [1:0]       next_ch,
  output logic             frame_done,
  output logic             overrun
`ifdef DMUX4WAY4_PARITY_EN
  ,
  input  logic             in_par,
  output logic             par_err
`endif
);

  state_t     state, state_n;
  logic [3:0] mask_n;
  logic [1:0] ptr_n;
  logic       ovr_n;
  logic       prev_mode;
  logic       mode_chg;
  logic [3:0] base_mask;
  logic [1:0] base_ptr;
  logic [1:0] tgt;
  logic [3:0] tgt_bit;
  logic [3:0] new_mask;
  logic       accept;
  logic       load;

`ifdef DMUX4WAY4_PARITY_EN
  logic par_bad;
  assign par_bad = ^{in_data, in_par};
  assign accept  = in_valid & ~par_bad;

  // Flag a write dropped for bad parity, visible for one cycle.
  always_ff @(posedge clk) begin
    if (reset) par_err <= 1'b0;
    else       par_err <= in_valid & par_bad;
  end
`else
  assign accept = in_valid;
`endif

  // A mode flip abandons the frame in progress; the same-edge write then
  // sees an empty mask and pointer 0, making it the first write of a new frame.
  always_comb begin
    mode_chg  = (auto_mode != prev_mode);
    base_mask = mode_chg ? 4'b0000 : out_valid;
    base_ptr  = mode_chg ? 2'd0 : next_ch;
    tgt       = auto_mode ? base_ptr : sel;
    tgt_bit   = 4'b0001 << tgt;
    new_mask  = base_mask | tgt_bit;
    load      = accept & ~clear;
  end

  // Next-state, mask, pointer and overrun; clear outranks writes.
  always_comb begin
    state_n = state;
    mask_n  = out_valid;
    ptr_n   = next_ch;
    ovr_n   = overrun;
    if (clear) begin
      state_n = S_IDLE;
      mask_n  = '0;
      ptr_n   = '0;
      ovr_n   = 1'b0;
    end else begin
      if (mode_chg) begin
        state_n = S_IDLE;
        mask_n  = '0;
        ptr_n   = '0;
      end else if (state == S_DONE) begin
        state_n = S_IDLE;
      end
      if (accept) begin
        ovr_n = overrun | (|(base_mask & tgt_bit));
        if (new_mask == FULL_MASK) begin
          state_n = S_DONE;
          mask_n  = '0;
          ptr_n   = '0;
        end else begin
          state_n = S_FILL;
          mask_n  = new_mask;
          ptr_n   = auto_mode ? 2'(base_ptr + 2'd1) : 2'd0;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    prev_mode <= auto_mode;
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= '0;
      next_ch   <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= mask_n;
      next_ch   <= ptr_n;
      overrun   <= ovr_n;
    end
  end

  assign frame_done = (state == S_DONE);

  dmux_ch_reg #(.WIDTH(WIDTH)) u_ch_a (
    .clk(clk), .reset(reset), .load(load && tgt == CH_A), .d(in_data), .q(a));
  dmux_ch_reg #(.WIDTH(WIDTH)) u_ch_b (
    .clk(clk), .reset(reset), .load(load && tgt == CH_B), .d(in_data), .q(b));
  dmux_ch_reg #(.WIDTH(WIDTH)) u_ch_c (
    .clk(clk), .reset(reset), .load(load && tgt == CH_C), .d(in_data), .q(c));
  dmux_ch_reg #(.WIDTH(WIDTH)) u_ch_d (
    .clk(clk), .reset(reset), .load(load && tgt == CH_D), .d(in_data), .q(d));

endmodule

// File: tb/tb_dmux4way4_seq.sv
// Scoreboard bench for dmux4way4_seq: each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops and compares on negedge.
module tb_dmux4way4_seq;

  typedef struct packed {
    logic [3:0] a, b, c, d, ov;
    logic [1:0] nc;
    logic       fd, orr, pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, in_valid, auto_mode, clear;
  logic [3:0] in_data;
  logic [1:0] sel;
  logic [3:0] a, b, c, d, out_valid;
  logic [1:0] next_ch;
  logic       frame_done, overrun;
`ifdef DMUX4WAY4_PARITY_EN
  logic       in_par, par_err;
`endif

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmux4way4_seq #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .sel(sel), .auto_mode(auto_mode), .clear(clear),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .next_ch(next_ch),
    .frame_done(frame_done), .overrun(overrun)
`ifdef DMUX4WAY4_PARITY_EN
    , .in_par(in_par), .par_err(par_err)
`endif
  );

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] dat,
                      input logic [1:0] s, input logic am, input logic clr,
                      input logic pf, input logic [15:0] abcd,
                      input logic [3:0] ov, input logic [1:0] nc,
                      input logic fd, input logic orr, input logic pe);
    exp_t e;
    reset = rst; in_valid = v; in_data = dat; sel = s;
    auto_mode = am; clear = clr;
`ifdef DMUX4WAY4_PARITY_EN
    in_par = (^dat) ^ pf;
    e.pe = pe;
`else
    e.pe = 1'b0 & pf & pe;
`endif
    e.a = abcd[15:12]; e.b = abcd[11:8]; e.c = abcd[7:4]; e.d = abcd[3:0];
    e.ov = ov; e.nc = nc; e.fd = fd; e.orr = orr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, act;
      e = q.pop_front();
      act.a = a; act.b = b; act.c = c; act.d = d; act.ov = out_valid;
      act.nc = next_ch; act.fd = frame_done; act.orr = overrun;
`ifdef DMUX4WAY4_PARITY_EN
      act.pe = par_err;
`else
      act.pe = 1'b0;
`endif
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL cycle%0d: got abcd=%h%h%h%h ov=%b nc=%0d fd=%b or=%b pe=%b, want abcd=%h%h%h%h ov=%b nc=%0d fd=%b or=%b pe=%b",
                 total, act.a, act.b, act.c, act.d, act.ov, act.nc, act.fd, act.orr, act.pe,
                 e.a, e.b, e.c, e.d, e.ov, e.nc, e.fd, e.orr, e.pe);
      end
    end
  end

  initial begin
    //    rst v  dat    s  am c pf  abcd       ov       nc fd or pe
    // Reset
    step(1, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0);
    step(1, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0);
    // 1. Manual fill
    step(0, 1, 4'h3, 0, 0, 0, 0, 16'h3000, 4'b0001, 0, 0, 0, 0);
    step(0, 1, 4'h5, 1, 0, 0, 0, 16'h3500, 4'b0011, 0, 0, 0, 0);
    step(0, 1, 4'h9, 2, 0, 0, 0, 16'h3590, 4'b0111, 0, 0, 0, 0);
    step(0, 1, 4'hC, 3, 0, 0, 0, 16'h359C, 4'b0000, 0, 1, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 16'h359C, 4'b0000, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 16'h359C, 4'b0000, 0, 0, 0, 0);
    // 2. Auto round-robin, fifth write lands in a
    step(0, 1, 4'h1, 3, 1, 0, 0, 16'h159C, 4'b0001, 1, 0, 0, 0);
    step(0, 1, 4'h2, 3, 1, 0, 0, 16'h129C, 4'b0011, 2, 0, 0, 0);
    step(0, 1, 4'h3, 3, 1, 0, 0, 16'h123C, 4'b0111, 3, 0, 0, 0);
    step(0, 1, 4'h4, 3, 1, 0, 0, 16'h1234, 4'b0000, 0, 1, 0, 0);
    step(0, 1, 4'h5, 3, 1, 0, 0, 16'h5234, 4'b0001, 1, 0, 0, 0);
    // 4. Gaps/hold after clearing
    step(0, 0, 4'h0, 0, 1, 1, 0, 16'h5234, 4'b0000, 0, 0, 0, 0);
    step(0, 1, 4'h6, 0, 1, 0, 0, 16'h6234, 4'b0001, 1, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 0, 0, 16'h6234, 4'b0001, 1, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 0, 0, 16'h6234, 4'b0001, 1, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 0, 0, 16'h6234, 4'b0001, 1, 0, 0, 0);
    step(0, 1, 4'h7, 0, 1, 0, 0, 16'h6734, 4'b0011, 2, 0, 0, 0);
    // 5. Clear mid-frame drops the F write; then reset mid-frame
    step(0, 1, 4'hF, 0, 1, 1, 0, 16'h6734, 4'b0000, 0, 0, 0, 0);
    step(0, 1, 4'h8, 0, 1, 0, 0, 16'h8734, 4'b0001, 1, 0, 0, 0);
    step(0, 1, 4'h9, 0, 1, 0, 0, 16'h8934, 4'b0011, 2, 0, 0, 0);
    step(1, 1, 4'hF, 0, 1, 0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0);
    // 6. Mode switch mid-frame, then finish the manual frame
    step(0, 1, 4'h1, 0, 1, 0, 0, 16'h1000, 4'b0001, 1, 0, 0, 0);
    step(0, 1, 4'h2, 0, 1, 0, 0, 16'h1200, 4'b0011, 2, 0, 0, 0);
    step(0, 1, 4'hE, 3, 0, 0, 0, 16'h120E, 4'b1000, 0, 0, 0, 0);
    step(0, 1, 4'h4, 0, 0, 0, 0, 16'h420E, 4'b1001, 0, 0, 0, 0);
    step(0, 1, 4'h5, 1, 0, 0, 0, 16'h450E, 4'b1011, 0, 0, 0, 0);
    step(0, 1, 4'h6, 2, 0, 0, 0, 16'h456E, 4'b0000, 0, 1, 0, 0);
    // 3. Overrun: b written twice, frame completes only on 4 distinct
    step(0, 1, 4'h6, 1, 0, 0, 0, 16'h466E, 4'b0010, 0, 0, 0, 0);
    step(0, 1, 4'h7, 1, 0, 0, 0, 16'h476E, 4'b0010, 0, 0, 1, 0);
    step(0, 1, 4'h8, 0, 0, 0, 0, 16'h876E, 4'b0011, 0, 0, 1, 0);
    step(0, 1, 4'h9, 2, 0, 0, 0, 16'h879E, 4'b0111, 0, 0, 1, 0);
    step(0, 1, 4'hA, 3, 0, 0, 0, 16'h879A, 4'b0000, 0, 1, 1, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 16'h879A, 4'b0000, 0, 0, 1, 0);
    step(0, 0, 4'h0, 0, 0, 1, 0, 16'h879A, 4'b0000, 0, 0, 0, 0);
`ifdef DMUX4WAY4_PARITY_EN
    // Bad parity write dropped, par_err pulses once
    step(0, 1, 4'h3, 0, 0, 0, 1, 16'h879A, 4'b0000, 0, 0, 0, 1);
    step(0, 0, 4'h0, 0, 0, 0, 0, 16'h879A, 4'b0000, 0, 0, 0, 0);
    step(0, 1, 4'h3, 0, 0, 0, 0, 16'h379A, 4'b0001, 0, 0, 0, 0);
`endif
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #6;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
